// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory.
package im_loader_pkg;

  localparam int unsigned MEM_BYTES_DEF = 2048;
  localparam int unsigned LEN_W_DEF     = 12;
  localparam int unsigned ST_W          = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_LOAD = 2'd1;
  localparam logic [ST_W-1:0] ST_PAD  = 2'd2;
  localparam logic [ST_W-1:0] ST_FIN  = 2'd3;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  data;
  } mem_wr_t;

endpackage

// File: rtl/im_loader.sv
// Streams a program image into the instruction memory one byte per cycle,
// zero-pads the final word and holds the CPU in reset while loading.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter int unsigned LEN_W     = LEN_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [31:0]      i_base_addr,
  input  logic [LEN_W-1:0] i_length,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte,
  output logic             o_byte_ready,
  output logic             o_we,
  output logic [31:0]      o_waddr,
  output logic [7:0]       o_wdata,
  output logic             o_busy,
  output logic             o_cpu_hold,
  output logic             o_done,
  output logic             o_err,
  output logic [7:0]       o_checksum
);

  logic [ST_W-1:0]  r_state, w_state_nxt;
  logic [31:0]      r_base, w_base_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [LEN_W-1:0] r_idx, w_idx_nxt;
  mem_wr_t          r_wr, w_wr_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic [7:0]       r_sum, w_sum_nxt;

  logic w_xfer;
  logic w_last;
  logic w_bad;

  assign w_xfer = i_byte_valid & r_ready;
  assign w_last = (r_idx == r_len - LEN_W'(1));
  // 33-bit compare so a base near 2^32 cannot wrap past the bound check
  assign w_bad  = (i_base_addr[1:0] != 2'b00) ||
                  (({1'b0, i_base_addr} + 33'(i_length)) > 33'(MEM_BYTES));

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_wr_nxt    = r_wr;
    w_wr_nxt.we = 1'b0;
    w_ready_nxt = r_ready;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_sum_nxt   = r_sum;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_base_nxt = i_base_addr;
          w_len_nxt  = i_length;
          w_idx_nxt  = '0;
          w_err_nxt  = 1'b0;
          w_sum_nxt  = 8'h00;
          if (w_bad) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_FIN;
          end else if (i_length == '0) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_ready_nxt = 1'b1;
            w_state_nxt = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (w_xfer) begin
          w_wr_nxt.we   = 1'b1;
          w_wr_nxt.addr = r_base + 32'(r_idx);
          w_wr_nxt.data = i_byte;
          w_sum_nxt     = r_sum + i_byte;
          w_idx_nxt     = r_idx + LEN_W'(1);
          if (w_last) begin
            w_ready_nxt = 1'b0;
            w_state_nxt = (r_len[1:0] != 2'b00) ? ST_PAD : ST_FIN;
          end
        end
      end
      ST_PAD: begin
        w_wr_nxt.we   = 1'b1;
        w_wr_nxt.addr = r_base + 32'(r_idx);
        w_wr_nxt.data = 8'h00;
        w_idx_nxt     = r_idx + LEN_W'(1);
        if (r_idx[1:0] == 2'b11) begin
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_ready_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_base  <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_wr    <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_sum   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_len   <= w_len_nxt;
      r_idx   <= w_idx_nxt;
      r_wr    <= w_wr_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_sum   <= w_sum_nxt;
    end
  end

  assign o_byte_ready = r_ready;
  assign o_we         = r_wr.we;
  assign o_waddr      = r_wr.addr;
  assign o_wdata      = r_wr.data;
  assign o_busy       = r_busy;
  assign o_cpu_hold   = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_checksum   = r_sum;

endmodule

// File: tb/tb_im_loader.sv
// Directed and randomized loads checked against a byte-level model of the image.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [31:0] i_base_addr;
  logic [11:0] i_length;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        o_byte_ready, o_we, o_busy, o_cpu_hold, o_done, o_err;
  logic [31:0] o_waddr;
  logic [7:0]  o_wdata, o_checksum;

  int vec_cnt = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  int viol = 0;
  int obs_addr[$];
  logic [7:0] obs_data[$];
  logic [7:0] mem [2048];
  logic [7:0] tx[$];
  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  im_loader dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_length(i_length), .i_byte_valid(i_byte_valid), .i_byte(i_byte),
    .o_byte_ready(o_byte_ready), .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_busy(o_busy), .o_cpu_hold(o_cpu_hold), .o_done(o_done), .o_err(o_err),
    .o_checksum(o_checksum)
  );

  always #5 clk = ~clk;

  // Observe the memory write port and protocol invariants away from the active edge
  always @(negedge clk) begin
    if (o_we) begin
      obs_addr.push_back(int'(o_waddr));
      obs_data.push_back(o_wdata);
      if (o_waddr < 32'd2048) mem[o_waddr[10:0]] = o_wdata;
    end
    if (o_done) done_cnt++;
    if (o_we && (o_done || o_err || o_waddr >= 32'd2048)) viol++;
    if (o_cpu_hold !== o_busy) viol++;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({o_byte_ready, o_we, o_waddr, o_wdata, o_busy, o_cpu_hold, o_done, o_err, o_checksum});
  endfunction

  task automatic run_load(input string tag, input logic [31:0] base, input int len,
                          input int vmode, input int start_at, input int abort_after);
    int exp_addr[$];
    logic [7:0] exp_data[$];
    logic [7:0] sum;
    bit bad;
    int d0, k, n, pi;
    bit v, rdy;
    sum = 8'h00;
    bad = (base[1:0] != 2'b00) || ((64'(base) + 64'(len)) > 64'd2048);
    if (!bad) begin
      for (int i = 0; i < len; i++) begin
        exp_addr.push_back(int'(base) + i);
        exp_data.push_back(tx[i]);
        sum = sum + tx[i];
      end
      for (int j = len; (j % 4) != 0; j++) begin
        exp_addr.push_back(int'(base) + j);
        exp_data.push_back(8'h00);
      end
    end
    obs_addr.delete();
    obs_data.delete();
    d0 = done_cnt;
    viol = 0;

    @(posedge clk); #1;
    i_start = 1'b1; i_base_addr = base; i_length = 12'(len);
    @(posedge clk); #1;
    i_start = 1'b0;
    if (!bad && len > 0) chk({tag, "_busy"}, 64'(o_busy), 64'd1);

    k = 0; n = 0; pi = 0;
    while (!bad && k < len && n < 4000) begin
      if (abort_after >= 0 && k == abort_after) break;
      case (vmode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: begin v = (pi < 7) ? pat[pi] : 1'b1; pi++; end
      endcase
      if (n == start_at) begin
        v = 1'b0;
        i_start = 1'b1; i_base_addr = 32'h100; i_length = 12'd4;
      end
      i_byte_valid = v;
      i_byte = tx[k];
      rdy = o_byte_ready;
      @(posedge clk); #1;
      i_start = 1'b0;
      if (v && rdy) k++;
      n++;
    end
    i_byte_valid = 1'b0;

    if (abort_after >= 0) begin
      #3 i_rst_n = 1'b0;
      #1 chk({tag, "_rst_outs"}, all_outs(), 64'd0);
      repeat (3) @(posedge clk);
      #1 i_rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk({tag, "_rst_nodone"}, 64'(done_cnt - d0), 64'd0);
      chk({tag, "_rst_idle"}, all_outs(), 64'd0);
      return;
    end

    n = 0;
    while (done_cnt == d0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_nwr"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      chk({tag, "_addr"}, 64'(obs_addr[i]), 64'(exp_addr[i]));
      chk({tag, "_data"}, 64'(obs_data[i]), 64'(exp_data[i]));
    end
    chk({tag, "_err"}, 64'(o_err), 64'(bad));
    chk({tag, "_csum"}, 64'(o_checksum), 64'(sum));
    chk({tag, "_idle"}, 64'({o_busy, o_byte_ready, o_we}), 64'd0);
    chk({tag, "_viol"}, 64'(viol), 64'd0);
  endtask

  initial begin
    int len;
    logic [31:0] base;
    int d0;
    i_rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_length = '0;
    i_byte_valid = 1'b0; i_byte = '0;
    repeat (2) @(posedge clk);
    #1 chk("reset_outs", all_outs(), 64'd0);
    i_rst_n = 1'b1;

    tx = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
    run_load("b2b8", 32'd0, 8, 0, -1, -1);
    chk("word0", 64'({mem[0], mem[1], mem[2], mem[3]}), 64'h8C010004);
    chk("word4", 64'({mem[4], mem[5], mem[6], mem[7]}), 64'hAC020008);

    tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_load("pad5", 32'd16, 5, 0, -1, -1);
    chk("word20", 64'({mem[20], mem[21], mem[22], mem[23]}), 64'h55000000);

    tx = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_load("bubbles", 32'd0, 4, 2, -1, -1);

    tx.delete();
    for (int i = 0; i < 12; i++) tx.push_back(8'($urandom));
    run_load("start_busy", 32'd64, 12, 0, 3, -1);

    run_load("misalign", 32'd2, 4, 0, -1, -1);
    run_load("overflow", 32'd2044, 8, 0, -1, -1);
    tx = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load("top_word", 32'd2044, 4, 0, -1, -1);
    chk("word2044", 64'({mem[2044], mem[2045], mem[2046], mem[2047]}), 64'hDEADBEEF);

    d0 = done_cnt;
    @(posedge clk); #1;
    i_start = 1'b1; i_base_addr = 32'd8; i_length = 12'd0;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("len0_c1_done", 64'(o_done), 64'd0);
    @(posedge clk); #1;
    chk("len0_c2_done", 64'(o_done), 64'd1);
    chk("len0_err", 64'(o_err), 64'd0);
    @(posedge clk); #1;
    chk("len0_c3_done", 64'(o_done), 64'd0);
    chk("len0_pulses", 64'(done_cnt - d0), 64'd1);

    tx.delete();
    for (int i = 0; i < 8; i++) tx.push_back(8'($urandom));
    run_load("abort", 32'd128, 8, 0, -1, 3);
    run_load("after_abort", 32'd128, 8, 0, -1, -1);

    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 40);
      base = 32'($urandom_range(0, (2048 - len) / 4) * 4);
      tx.delete();
      for (int i = 0; i < len; i++) tx.push_back(8'($urandom));
      run_load("rand", base, len, 1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
